csa_accum_ctrl: RTL and testbench

Sequencer for the 32-bit carry-save / lookahead adder datapath. Accepts a counted stream of operands over a valid/ready handshake and accumulates them in redundant (sum, carry) form, one carry-save step per accepted operand. After the last operand it runs a single carry-propagate resolve step and returns the W-bit result over a valid/ready output handshake. It sits between an operand source (e.g. partial-product generator, dot-product front end) and its result consumer.

---
 rtl/csa_accum_ctrl.sv | 155 +++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl
// Sequencer for a carry-save accumulator. Operands arrive over a valid/ready
// handshake and are folded into a redundant (sum, carry) pair, one
// carry-save step per accepted operand. After the last operand, one
// carry-propagate add resolves the pair. The W-bit result then leaves over
// a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, num_ops        job request and operand count, sampled in IDLE
//   busy                  high whenever not IDLE
//   in_valid/in_ready     operand handshake, in_data = operand
//   out_valid/out_ready   result handshake, out_data = sum mod 2^W
//   ovf                   only when CSA_ACCUM_OVF_EN is defined: sticky
//                         flag set when the true unsigned sum exceeds
//                         2^W-1, valid with out_valid
//
// Optional feature macro: CSA_ACCUM_OVF_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; num_ops latched (saturated) on start
// ACCUM   | accepting operands, one carry-save step per transfer
// RESOLVE | single carry-propagate add of sum_r + carry_r
// DONE    | result presented until the consumer takes it
module csa_accum_ctrl #(
  parameter  int W       = 32,
  parameter  int MAX_OPS = 16,
  localparam int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data
`ifdef CSA_ACCUM_OVF_EN
  ,
  output logic          ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CW-1:0] MAX_N = CW'(MAX_OPS);

  state_t        state, state_nxt;
  logic [W-1:0]  sum_r, carry_r;
  logic [CW-1:0] count, n_r;
  logic [CW-1:0] n_sat;
  logic [CW-1:0] count_inc;
  logic          xfer;
  logic [W-1:0]  sum_nxt, carry_nxt;

  assign n_sat     = (num_ops > MAX_N) ? MAX_N : num_ops;
  assign count_inc = count + 1'b1;
  assign xfer      = in_valid && in_ready;

  // The W-bit shift drops the majority MSB; that dropped bit is exactly
  // the weight-2^W carry lost to the modulo.
  assign sum_nxt   = sum_r ^ carry_r ^ in_data;
  assign carry_nxt = ((sum_r & carry_r) | (sum_r & in_data) | (carry_r & in_data)) << 1;

`ifdef CSA_ACCUM_OVF_EN
  logic         maj_msb;
  logic [W:0]   resolve_full;
  assign maj_msb      = (sum_r[W-1] & carry_r[W-1]) | (sum_r[W-1] & in_data[W-1]) |
                        (carry_r[W-1] & in_data[W-1]);
  assign resolve_full = {1'b0, sum_r} + {1'b0, carry_r};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (n_sat == '0) ? RESOLVE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (count_inc == n_r)) state_nxt = RESOLVE;
      end
      RESOLVE: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r    <= '0;
      carry_r  <= '0;
      out_data <= '0;
      count    <= '0;
      n_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_r     <= n_sat;
            sum_r   <= '0;
            carry_r <= '0;
            count   <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            sum_r   <= sum_nxt;
            carry_r <= carry_nxt;
            count   <= count_inc;
          end
        end
        RESOLVE: out_data <= sum_r + carry_r;
        default: ;
      endcase
    end
  end

`ifdef CSA_ACCUM_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) ovf <= 1'b0;
        ACCUM:   if (xfer && maj_msb) ovf <= 1'b1;
        RESOLVE: if (resolve_full[W]) ovf <= 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;
  localparam int W       = 32;
  localparam int MAX_OPS = 16;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_ops;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          ovf_obs;

`ifdef CSA_ACCUM_OVF_EN
  logic ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  csa_accum_ctrl #(.W(W), .MAX_OPS(MAX_OPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_ops   (num_ops),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CSA_ACCUM_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] ops [32];

  // Reference: the job result is simply the arithmetic sum of the first
  // min(n, MAX_OPS) operands; overflow means that sum does not fit in W bits.
  function automatic longint unsigned model_total(input int n);
    longint unsigned s = 0;
    int k = (n > MAX_OPS) ? MAX_OPS : n;
    for (int i = 0; i < k; i++) s += longint'(ops[i]);
    return s;
  endfunction

  function automatic logic [W-1:0] model_res(input int n);
    longint unsigned s = model_total(n);
    return s[W-1:0];
  endfunction

  function automatic logic model_ovf(input int n);
    return (model_total(n) >> W) != 0;
  endfunction

  // Drives one job from IDLE to the result transfer. Returns to the caller
  // one time unit after the edge on which the result was taken.
  task automatic run_job(input int n_req, input int gap_min, input int gap_max,
                         input int ready_delay, input bit hold_start,
                         output logic [W-1:0] res, output logic res_ovf,
                         output int accepted, output int lat, output int first_rdy,
                         output bit saw_rdy, output bit unstable, output bit timeout);
    int cyc, last_edge, gap, held;
    bit seen_valid, took;
    res = '0; res_ovf = 1'b0; accepted = 0; lat = -1; first_rdy = -1;
    saw_rdy = 0; unstable = 0; timeout = 0; seen_valid = 0; held = 0;
    start = 1'b1;
    num_ops = n_req[CW-1:0];
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1; last_edge = 1;
    if (hold_start) num_ops = CW'($urandom_range(3, 1));
    else start = 1'b0;
    gap = $urandom_range(gap_max, gap_min);
    forever begin
      if (cyc > 600) begin timeout = 1; break; end
      if (out_valid) begin
        if (!seen_valid) begin
          seen_valid = 1;
          lat = cyc - last_edge + 1;
          res = out_data;
          res_ovf = ovf_obs;
        end else if (out_data !== res) begin
          unstable = 1;
        end
        out_ready = (held >= ready_delay);
        took = out_ready;
        held++;
        @(posedge clk); #1; cyc++;
        out_ready = 1'b0;
        if (took) break;
      end else if (in_ready) begin
        if (!saw_rdy) begin saw_rdy = 1; first_rdy = cyc; end
        if (gap > 0) begin
          in_valid = 1'b0; in_data = $urandom; gap--;
        end else begin
          in_valid = 1'b1; in_data = (accepted < 32) ? ops[accepted] : '0;
        end
        @(posedge clk); #1; cyc++;
        if (in_valid) begin
          accepted++;
          last_edge = cyc;
          gap = $urandom_range(gap_max, gap_min);
        end
        in_valid = 1'b0;
        in_data = $urandom;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
  endtask

  logic [W-1:0] r_res;
  logic         r_ovf;
  int           r_acc, r_lat, r_rdy;
  bit           r_saw, r_unst, r_to;

  task automatic test_reset();
    total++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0)
      $display("FAIL reset_values got busy=%b in_ready=%b out_valid=%b out_data=%h want 0 0 0 0",
               busy, in_ready, out_valid, out_data);
    else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_ops = CW'(5);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = W'(100 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_pre_accum got in_ready=%b busy=%b want 1 1", in_ready, busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, in_ready, out_valid} !== 3'b000)
      $display("FAIL reset_abort got busy=%b in_ready=%b out_valid=%b want 0 0 0",
               busy, in_ready, out_valid);
    else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    ops[0] = 32'd7; ops[1] = 32'd8;
    run_job(2, 0, 0, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'd15)
      $display("FAIL reset_next_job got %h timeout=%0d want %h", r_res, r_to, 32'd15);
    else passed++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) ops[i] = W'(i + 1);
    run_job(4, 0, 0, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'd10)
      $display("FAIL basic_sum got %h timeout=%0d want %h", r_res, r_to, 32'd10);
    else passed++;
    // Counting the final transfer edge itself, out_valid is seen after the 2nd edge.
    total++;
    if (r_lat !== 2) $display("FAIL basic_latency got %0d edges want 2", r_lat);
    else passed++;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_pulse got out_valid=%b busy=%b want 0 0", out_valid, busy);
    else passed++;
  endtask

  task automatic test_stall();
    ops[0] = 32'hFFFF_FFFF; ops[1] = 32'd1; ops[2] = 32'd5;
    run_job(3, 2, 2, 4, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'h0000_0005)
      $display("FAIL stall_sum got %h timeout=%0d want %h", r_res, r_to, 32'h5);
    else passed++;
    total++;
    if (r_unst) $display("FAIL stall_hold got unstable=1 want 0");
    else passed++;
`ifdef CSA_ACCUM_OVF_EN
    total++;
    if (r_ovf !== 1'b1) $display("FAIL stall_ovf got %b want 1", r_ovf);
    else passed++;
`endif
  endtask

  task automatic test_carry_chains();
    for (int i = 0; i < 16; i++) ops[i] = 32'h0FFF_FFFF;
    run_job(16, 0, 0, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'hFFFF_FFF0)
      $display("FAIL chain_fff got %h want %h", r_res, 32'hFFFF_FFF0);
    else passed++;
`ifdef CSA_ACCUM_OVF_EN
    total++;
    if (r_ovf !== 1'b0) $display("FAIL chain_fff_ovf got %b want 0", r_ovf);
    else passed++;
`endif
    for (int i = 0; i < 16; i++) ops[i] = 32'h1000_0000;
    run_job(16, 0, 0, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'h0)
      $display("FAIL chain_wrap got %h want %h", r_res, 32'h0);
    else passed++;
`ifdef CSA_ACCUM_OVF_EN
    total++;
    if (r_ovf !== 1'b1) $display("FAIL chain_wrap_ovf got %b want 1", r_ovf);
    else passed++;
`endif
  endtask

  task automatic test_boundaries();
    logic [W-1:0] exp;
    run_job(0, 0, 0, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== '0 || r_saw || r_lat !== 2)
      $display("FAIL zero_ops got res=%h in_ready_seen=%0d lat=%0d want 0 0 2",
               r_res, r_saw, r_lat);
    else passed++;
    for (int i = 0; i < 32; i++) ops[i] = $urandom;
    exp = model_res(20);
    run_job(20, 0, 1, 0, 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_acc !== 16 || r_res !== exp)
      $display("FAIL saturate got accepted=%0d res=%h want 16 %h", r_acc, r_res, exp);
    else passed++;
    for (int i = 0; i < 4; i++) ops[i] = $urandom;
    exp = model_res(4);
    run_job(4, 0, 2, 1, 1, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    start = 1'b0;
    total++;
    if (r_to || r_acc !== 4 || r_res !== exp)
      $display("FAIL start_ignored got accepted=%0d res=%h want 4 %h", r_acc, r_res, exp);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) $display("FAIL start_idle got busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    ops[0] = 32'hA;
    run_job(1, 0, 0, 0, 1, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    total++;
    if (r_to || r_res !== 32'hA) $display("FAIL b2b_first got %h want %h", r_res, 32'hA);
    else passed++;
    ops[0] = 32'h3; ops[1] = 32'h4;
    run_job(2, 0, 0, 0, 1, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw, r_unst, r_to);
    start = 1'b0;
    total++;
    if (r_to || r_res !== 32'h7) $display("FAIL b2b_second got %h want %h", r_res, 32'h7);
    else passed++;
    total++;
    if (r_rdy !== 1)
      $display("FAIL b2b_ready got in_ready after %0d edges want 1", r_rdy);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n;
    logic [W-1:0] exp;
    logic exp_ovf;
    for (int j = 0; j < 12; j++) begin
      n = $urandom_range(20, 0);
      for (int i = 0; i < 32; i++)
        ops[i] = (j % 2 == 0) ? W'($urandom_range(32'h0FFF_FFFF, 0)) : W'($urandom);
      exp = model_res(n);
      exp_ovf = model_ovf(n);
      run_job(n, 0, 3, $urandom_range(3, 0), 0, r_res, r_ovf, r_acc, r_lat, r_rdy, r_saw,
              r_unst, r_to);
      total++;
      if (r_to || r_res !== exp || r_acc !== ((n > MAX_OPS) ? MAX_OPS : n))
        $display("FAIL random_job%0d n=%0d got res=%h accepted=%0d want %h %0d",
                 j, n, r_res, r_acc, exp, (n > MAX_OPS) ? MAX_OPS : n);
      else passed++;
`ifdef CSA_ACCUM_OVF_EN
      total++;
      if (r_ovf !== exp_ovf)
        $display("FAIL random_ovf%0d got %b want %b", j, r_ovf, exp_ovf);
      else passed++;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_ops = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_carry_chains();
    test_boundaries();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
